// File: rtl/mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mult_seq
//  Description : Sequential shift-add multiplier. Computes a 2*WIDTH-bit
//                product of two WIDTH-bit operands in WIDTH iterations.
//                Optional macro MULT_SEQ_SIGNED_EN adds a signed_op input:
//                signed_op=1 selects a two's-complement multiply, 0 unsigned.
//  Revision    : 1.0  - initial release
// ============================================================================
module mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
`ifdef MULT_SEQ_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Iteration counter is 5 bits; the last RUN cycle is the one where it
    // reads WIDTH-1, and for WIDTH=32 it wraps back to 0 on that edge.
    localparam logic [4:0] c_LAST = 5'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [4:0]           r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_prod;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_shift;
    logic [2*WIDTH-1:0]   w_final;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_neg;

    // One shift-add step: conditional add into the upper half keeping the
    // carry, then shift the whole register right with the carry as new MSB.
    assign w_addend = r_prod[0] ? r_mcand : '0;
    assign w_sum    = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_shift  = {w_sum, r_prod[WIDTH-1:1]};

`ifdef MULT_SEQ_SIGNED_EN
    logic r_neg;

    // Signed mode multiplies magnitudes and fixes the sign at the end.
    assign w_a_mag = (signed_op && dataA[WIDTH-1]) ? -dataA : dataA;
    assign w_b_mag = (signed_op && dataB[WIDTH-1]) ? -dataB : dataB;
    assign w_neg   = signed_op && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
    assign w_final = r_neg ? -w_shift : w_shift;

    // Sign-correction flag captured with the operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_neg <= w_neg;
        end
    end
`else
    assign w_a_mag = dataA;
    assign w_b_mag = dataB;
    assign w_neg   = 1'b0;
    assign w_final = w_shift;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and status outputs decoded from the current state.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (r_cnt == c_LAST) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result publication.
    // hi/lo only change on the edge that completes the last iteration, so
    // partial sums never appear on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_mcand <= '0;
            r_prod  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mcand <= w_a_mag;
                        r_prod  <= {{WIDTH{1'b0}}, w_b_mag};
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_prod <= w_shift;
                    r_cnt  <= r_cnt + 5'd1;
                    if (r_cnt == c_LAST) begin
                        {r_hi, r_lo} <= w_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_seq
//  Description : Directed self-checking bench for mult_seq (WIDTH=32).
//                Builds with or without MULT_SEQ_SIGNED_EN.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_mult_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] dataA;
    logic [31:0] dataB;
`ifdef MULT_SEQ_SIGNED_EN
    logic        signed_op;
`endif
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_pass;

    mult_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dataA     (dataA),
        .dataB     (dataB),
`ifdef MULT_SEQ_SIGNED_EN
        .signed_op (signed_op),
`endif
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive an operation and count edges (including the accepting edge)
    // until done is seen; n = -1 if it never appears within the bound.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input bit hold, output int n);
        dataA = a;
        dataB = b;
        start = 1'b1;
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (!hold && i == 1) start = 1'b0;
            if (done) begin
                n = i;
                break;
            end
        end
        if (!hold) start = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        dataA = 32'd5;
        dataB = 32'd5;
        repeat (3) tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else n_pass++;
        n_checks++; if (hi !== 32'h0) $display("FAIL reset_hi got=%h want=0", hi); else n_pass++;
        n_checks++; if (lo !== 32'h0) $display("FAIL reset_lo got=%h want=0", lo); else n_pass++;
        start = 1'b0;
        rst   = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_start_ignored busy=%b want=0", busy); else n_pass++;
    endtask

    task automatic test_basic();
        int n;
        dataA = 32'd7;
        dataB = 32'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy got=%b want=1", busy); else n_pass++;
        n = 1;
        for (int i = 2; i <= 100; i++) begin
            tick();
            if (done) begin n = i; break; end
            if (i == 100) n = -1;
        end
        n_checks++; if (n != 33) $display("FAIL basic_latency got=%0d want=33", n); else n_pass++;
        n_checks++; if (hi !== 32'h0) $display("FAIL basic_hi got=%h want=00000000", hi); else n_pass++;
        n_checks++; if (lo !== 32'h3F) $display("FAIL basic_lo got=%h want=0000003f", lo); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL basic_idle done=%b busy=%b want=0,0", done, busy); else n_pass++;
    endtask

    task automatic test_unsigned_vectors();
        logic [31:0] va [4] = '{32'hFFFF_FFFF, 32'h0, 32'h0001_0000, 32'h8000_0000};
        logic [31:0] vb [4] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0001_0000, 32'd2};
        logic [63:0] ex [4] = '{64'hFFFF_FFFE_0000_0001, 64'h0, 64'h1_0000_0000, 64'h1_0000_0000};
        int n;
        for (int k = 0; k < 4; k++) begin
            do_op(va[k], vb[k], 1'b0, n);
            tick();
            n_checks++; if (n != 33) $display("FAIL umul%0d_latency got=%0d want=33", k, n); else n_pass++;
            n_checks++; if ({hi, lo} !== ex[k])
                $display("FAIL umul%0d_result got=%h_%h want=%h", k, hi, lo, ex[k]); else n_pass++;
        end
    endtask

`ifdef MULT_SEQ_SIGNED_EN
    task automatic test_signed();
        logic [31:0] va [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        logic [31:0] vb [3] = '{32'd2, 32'd2, 32'hFFFF_FFFB};
        logic        vs [3] = '{1'b1, 1'b0, 1'b1};
        logic [63:0] ex [3] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h1_FFFF_FFFE, 64'd15};
        int n;
        for (int k = 0; k < 3; k++) begin
            signed_op = vs[k];
            do_op(va[k], vb[k], 1'b0, n);
            tick();
            n_checks++; if (n != 33) $display("FAIL smul%0d_latency got=%0d want=33", k, n); else n_pass++;
            n_checks++; if ({hi, lo} !== ex[k])
                $display("FAIL smul%0d_result got=%h_%h want=%h", k, hi, lo, ex[k]); else n_pass++;
        end
        signed_op = 1'b0;
    endtask
`endif

    task automatic test_ignore_start();
        int dones;
        int first;
        dones = 0;
        first = -1;
        dataA = 32'd3;
        dataB = 32'd5;
        start = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 1) start = 1'b0;
            if (i == 5) begin
                dataA = 32'd4;
                dataB = 32'd4;
                start = 1'b1;
            end
            if (i == 10) start = 1'b0;
            if (done) begin
                dones++;
                if (first < 0) first = i;
            end
        end
        n_checks++; if (dones != 1) $display("FAIL ignore_done_count got=%0d want=1", dones); else n_pass++;
        n_checks++; if (first != 33) $display("FAIL ignore_latency got=%0d want=33", first); else n_pass++;
        n_checks++; if (hi !== 32'h0) $display("FAIL ignore_hi got=%h want=0", hi); else n_pass++;
        n_checks++; if (lo !== 32'd15) $display("FAIL ignore_lo got=%h want=0000000f", lo); else n_pass++;
    endtask

    task automatic test_abort();
        int dones;
        int n;
        dones = 0;
        dataA = 32'd100;
        dataB = 32'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL abort_pre_busy got=%b want=1", busy); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b want=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL abort_done got=%b want=0", done); else n_pass++;
        n_checks++; if (hi !== 32'h0 || lo !== 32'h0)
            $display("FAIL abort_hilo got=%h_%h want=0_0", hi, lo); else n_pass++;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) dones++;
        end
        n_checks++; if (dones != 0) $display("FAIL abort_no_done got=%0d want=0", dones); else n_pass++;
        do_op(32'd6, 32'd6, 1'b0, n);
        tick();
        n_checks++; if (n != 33) $display("FAIL abort_next_latency got=%0d want=33", n); else n_pass++;
        n_checks++; if (hi !== 32'h0 || lo !== 32'd36)
            $display("FAIL abort_next_result got=%h_%h want=0_24", hi, lo); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n;
        int gap;
        int idle;
        do_op(32'd3, 32'd7, 1'b1, n);
        n_checks++; if (n != 33) $display("FAIL b2b_first_latency got=%0d want=33", n); else n_pass++;
        for (int r = 0; r < 2; r++) begin
            gap  = -1;
            idle = 0;
            for (int i = 1; i <= 100; i++) begin
                tick();
                if (!busy && !done) idle++;
                if (done) begin gap = i; break; end
            end
            n_checks++; if (gap != 34) $display("FAIL b2b_period%0d got=%0d want=34", r, gap); else n_pass++;
            n_checks++; if (idle != 1) $display("FAIL b2b_idle%0d got=%0d want=1", r, idle); else n_pass++;
        end
        start = 1'b0;
        n_checks++; if (hi !== 32'h0 || lo !== 32'd21)
            $display("FAIL b2b_result got=%h_%h want=0_15", hi, lo); else n_pass++;
        repeat (2) tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dataA    = '0;
        dataB    = '0;
`ifdef MULT_SEQ_SIGNED_EN
        signed_op = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_basic();
        test_unsigned_vectors();
`ifdef MULT_SEQ_SIGNED_EN
        test_signed();
`endif
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits; the product is 2*WIDTH bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiply, sampled only in IDLE.
REQ-005 SHALL have port dataA, input, WIDTH bits: multiplicand, latched on the accepted start.
REQ-006 SHALL have port dataB, input, WIDTH bits: multiplier, latched on the accepted start.
REQ-007 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when hi/lo are newly valid.
REQ-009 SHALL have port hi, output, WIDTH bits: upper half of the product register.
REQ-010 SHALL have port lo, output, WIDTH bits: lower half of the product register.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-012 SHALL move IDLE->RUN when start=1 at a rising edge in IDLE, latching dataA and dataB and clearing the 5-bit iteration counter.
REQ-013 SHALL, in RUN, iterate by shift-add: if product[0]=1, add the multiplicand into the upper (WIDTH+1)-bit partial sum, keeping the carry; then shift the whole product register right by 1, with the carry entering the MSB.
REQ-014 SHALL stay in RUN for exactly WIDTH cycles, then move to DONE; for WIDTH=32 the counter wraps from 31 to 0 on exit.
REQ-015 SHALL present the final product on hi/lo on the edge entering DONE, hold done=1 for that single cycle, and return to IDLE on the next edge.
REQ-016 SHALL give a start-to-done latency of WIDTH+1 edges: start sampled at edge k, busy=1 after edges k..k+WIDTH-1, done=1 after edge k+WIDTH.
REQ-017 SHALL ignore start while in RUN or DONE; no re-latch and no queuing occurs.
REQ-018 SHALL hold hi/lo at their last completed result in IDLE, RUN and DONE; intermediate partial sums are kept in an internal register and are not driven on hi/lo.
REQ-019 SHALL accept back-to-back operations: start asserted in the IDLE cycle following DONE is accepted.
REQ-020 SHALL give operand 0 a result of 0 with normal latency; there is no early termination.

Reset
REQ-021 SHALL, when rst=1 at a rising edge, force state to IDLE, busy=0, done=0, hi=0, lo=0, and clear the counter and internal registers.
REQ-022 SHALL give rst priority over start and over any in-flight RUN; an aborted operation never asserts done.
REQ-023 SHALL treat start asserted in the same cycle as rst as ignored.

Configuration
REQ-024 SHALL, when macro MULT_SEQ_SIGNED_EN is defined, add input port signed_op, 1 bit, latched with the operands; signed_op=1 means a two's-complement multiply (MIPS MULT); signed_op=0 means unsigned (MULTU).
REQ-025 SHALL, with MULT_SEQ_SIGNED_EN defined and signed_op=1, multiply the operand magnitudes unsigned and negate the 2*WIDTH-bit product at DONE entry if the operand signs differ, keeping the same latency.
REQ-026 SHALL, without MULT_SEQ_SIGNED_EN, omit the signed_op port and perform unsigned multiplication only.

Verification
REQ-027 SHALL cover: rst then start with dataA=7, dataB=9 -> done pulse exactly 33 edges after start, hi=0x00000000, lo=0x0000003F.
REQ-028 SHALL cover: dataA=0xFFFFFFFF, dataB=0xFFFFFFFF unsigned -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-029 SHALL cover: with MULT_SEQ_SIGNED_EN, signed_op=1, dataA=0xFFFFFFFF (-1), dataB=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE; with signed_op=0 -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-030 SHALL cover: start with 3x5, then a second start with 4x4 while busy=1 -> only a single done, hi=0, lo=15.
REQ-031 SHALL cover: rst asserted 10 cycles into RUN -> busy=0, done stays 0, hi=lo=0 on the next edge; a new 6x6 op then completes with lo=36.
REQ-032 SHALL cover: start held high continuously -> done every 34 edges and busy=0 for exactly one IDLE cycle between operations.
